swt_reduce_debounce: RTL and testbench

Parametrised switch-reduction unit for the board I/O layer. It synchronises and debounces an N-bit switch bank, applies a runtime-selectable reduction (AND/OR/XOR/NAND), and registers the result for LED drive. It also flags rising edges of the result and keeps a saturating count of them. It is the clocked, generalised successor to the fixed combinational 4-input AND used on the switch/LED path.

---
 rtl/swt_reduce_debounce.sv | 131 +++++++++++++
 tb/tb_swt_reduce_debounce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/swt_reduce_debounce.sv
// Switch-bank synchroniser, per-bit debouncer, runtime-selectable reduction and rise-event counter.
// Define SWT_DEBOUNCE_EN to build the debounce counters; without it the stable bits follow sync2 directly.
module swt_reduce_debounce #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     swt,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             red_out,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] evt_cnt
);

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_NAND = 2'b11
    } mode_e;

    if (N < 1 || DB_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("swt_reduce_debounce: N, DB_CYCLES and CNT_W must all be >= 1");
    end

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;
    logic [N-1:0] stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= swt;
            sync2_q <= sync1_q;
        end
    end

`ifdef SWT_DEBOUNCE_EN
    localparam int                DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [N-1:0]    stable_q;
    logic [N-1:0]    stable_d;
    logic [DB_W-1:0] db_cnt_q [N];
    logic [DB_W-1:0] db_cnt_d [N];

    // Any sample equal to the stable value restarts the window from zero.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign stable = stable_q;
`else
    // Stable collapses onto sync2 so switch-to-LED stays at three edges.
    assign stable = sync2_q;
`endif

    logic             red_q;
    logic             red_d;
    logic             red_prev_q;
    logic [CNT_W-1:0] evt_cnt_q;
    logic [CNT_W-1:0] evt_cnt_d;

    always_comb begin
        red_d = 1'b0;
        case (mode_e'(mode))
            MODE_AND:  red_d = &stable;
            MODE_OR:   red_d = |stable;
            MODE_XOR:  red_d = ^stable;
            MODE_NAND: red_d = ~&stable;
            default:   red_d = 1'b0;
        endcase
    end

    assign rise_pulse = red_q & ~red_prev_q;

    // Clear wins over a coincident rise; the count holds at all-ones.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (cnt_clr) begin
            evt_cnt_d = '0;
        end else if (rise_pulse && (evt_cnt_q != {CNT_W{1'b1}})) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q      <= 1'b0;
            red_prev_q <= 1'b0;
            evt_cnt_q  <= '0;
        end else begin
            red_q      <= red_d;
            red_prev_q <= red_q;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign red_out = red_q;
    assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_swt_reduce_debounce.sv
// Testbench for swt_reduce_debounce (N=4, DB_CYCLES=4, CNT_W=3); follows SWT_DEBOUNCE_EN like the design.
module tb_swt_reduce_debounce;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int CW = 3;
`ifdef SWT_DEBOUNCE_EN
    localparam int LAT   = DB + 3;
    localparam bit DB_ON = 1'b1;
`else
    localparam int LAT   = 3;
    localparam bit DB_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  swt = '0;
    logic [1:0]    mode = 2'b00;
    logic          cnt_clr = 1'b0;
    logic          red_out;
    logic          rise_pulse;
    logic [CW-1:0] evt_cnt;

    always #5 clk = ~clk;

    swt_reduce_debounce #(.N(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .swt        (swt),
        .mode       (mode),
        .cnt_clr    (cnt_clr),
        .red_out    (red_out),
        .rise_pulse (rise_pulse),
        .evt_cnt    (evt_cnt)
    );

    typedef struct {
        logic [N-1:0] swt;
        logic [1:0]   mode;
        logic         clr;
        logic         exp_red;
    } vec_t;

    typedef struct {
        logic          red;
        logic          rise;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic          m_prev_red = 1'b0;
    logic          m_prev_rise = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    string         phase = "init";
    vec_t          sweep_tbl[6];

    task automatic check1(input string what, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s/%s: got %0d, expected %0d at %0t", phase, what, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s/scoreboard: got empty queue, expected an entry", phase);
        end else begin
            e = sb.pop_front();
            check1("red_out", 8'(red_out), 8'(e.red));
            check1("rise_pulse", 8'(rise_pulse), 8'(e.rise));
            check1("evt_cnt", 8'(evt_cnt), 8'(e.cnt));
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge, then compare.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        swt     = v.swt;
        mode    = v.mode;
        cnt_clr = v.clr;
        e.red   = v.exp_red;
        e.rise  = v.exp_red & ~m_prev_red;
        if (v.clr)
            e.cnt = '0;
        else if (m_prev_rise && m_cnt != {CW{1'b1}})
            e.cnt = m_cnt + 1'b1;
        else
            e.cnt = m_cnt;
        m_cnt       = e.cnt;
        m_prev_red  = e.red;
        m_prev_rise = e.rise;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Asserts reset between edges, checks the outputs clear at once, releases mid-cycle.
    task automatic doReset(input logic [N-1:0] s, input logic [1:0] m);
        swt     = s;
        mode    = m;
        cnt_clr = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check1("reset red_out", 8'(red_out), 8'd0);
        check1("reset rise_pulse", 8'(rise_pulse), 8'd0);
        check1("reset evt_cnt", 8'(evt_cnt), 8'd0);
        m_prev_red  = 1'b0;
        m_prev_rise = 1'b0;
        m_cnt       = '0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] s, input logic [1:0] m, input logic c, input logic r);
        vec_t v;
        v.swt = s;
        v.mode = m;
        v.clr = c;
        v.exp_red = r;
        return v;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sweep_tbl[0] = mk(4'b0110, 2'b00, 1'b0, 1'b0);
        sweep_tbl[1] = mk(4'b0110, 2'b01, 1'b0, 1'b1);
        sweep_tbl[2] = mk(4'b0110, 2'b10, 1'b0, 1'b0);
        sweep_tbl[3] = mk(4'b0110, 2'b11, 1'b0, 1'b1);
        sweep_tbl[4] = mk(4'b0110, 2'b11, 1'b0, 1'b1);
        sweep_tbl[5] = mk(4'b0110, 2'b00, 1'b0, 1'b0);

        @(posedge clk);
        #1;

        phase = "and_latency";
        doReset(4'b0000, 2'b00);
        for (int k = 1; k <= LAT + 3; k++)
            applyStimulus(mk(4'b1111, 2'b00, 1'b0, k >= LAT));
        check1("final evt_cnt", 8'(evt_cnt), 8'd1);

        phase = "glitch";
        for (int k = 1; k <= 6; k++)
            applyStimulus(mk((k == 1) ? 4'b1011 : 4'b1111, 2'b00, 1'b0, !(!DB_ON && k == 3)));

        if (DB_ON) begin
            phase = "bounce";
            doReset(4'b1110, 2'b00);
            for (int c = 0; c < 40; c++)
                applyStimulus(mk({3'b111, 1'((c % 4) != 3)}, 2'b00, 1'b0, 1'b0));
            for (int k = 1; k <= LAT + 1; k++)
                applyStimulus(mk(4'b1111, 2'b00, 1'b0, k >= LAT));
            check1("final evt_cnt", 8'(evt_cnt), 8'd1);
        end

        phase = "mode_sweep";
        doReset(4'b0110, 2'b00);
        for (int k = 1; k <= LAT + 1; k++)
            applyStimulus(mk(4'b0110, 2'b00, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++)
            applyStimulus(sweep_tbl[i]);
        check1("final evt_cnt", 8'(evt_cnt), 8'd2);

        phase = "saturate";
        doReset(4'b0000, 2'b00);
        for (int i = 0; i < 18; i++)
            applyStimulus(mk(4'b0000, (i % 2 == 0) ? 2'b11 : 2'b00, 1'b0, i % 2 == 0));
        check1("saturated evt_cnt", 8'(evt_cnt), 8'd7);
        applyStimulus(mk(4'b0000, 2'b11, 1'b0, 1'b1));
        check1("rise before clear", 8'(rise_pulse), 8'd1);
        applyStimulus(mk(4'b0000, 2'b11, 1'b1, 1'b1));
        check1("cleared evt_cnt", 8'(evt_cnt), 8'd0);
        applyStimulus(mk(4'b0000, 2'b00, 1'b0, 1'b0));

        phase = "reset_mid";
        doReset(4'b0000, 2'b00);
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(4'b0000, (i % 2 == 0) ? 2'b11 : 2'b00, 1'b0, i % 2 == 0));
        doReset(4'b0000, 2'b11);
        for (int k = 1; k <= 3; k++)
            applyStimulus(mk(4'b0000, 2'b11, 1'b0, 1'b1));
        check1("post-reset evt_cnt", 8'(evt_cnt), 8'd1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
